// File: rtl/fetch_pkg.sv
// Shared types and sizing constants for the buffered instruction fetch stage.
package fetch_pkg;

  localparam int PC_W     = 8;
  localparam int INSTR_W  = 16;
  localparam int FQ_DEPTH = 4;
  localparam int FQ_PTR_W = $clog2(FQ_DEPTH);
  localparam int FQ_CNT_W = FQ_PTR_W + 1;

  typedef logic [PC_W-1:0]     pc_t;
  typedef logic [INSTR_W-1:0]  instr_t;
  typedef logic [FQ_CNT_W-1:0] fq_cnt_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries between fetch and decode.
// Flush dominates push and pop; a pop from an empty queue is a no-op.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         empty_o,
  output fq_cnt_t      count_o
);

  fetch_entry_t          mem_q [FQ_DEPTH];
  logic [FQ_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FQ_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  fq_cnt_t               count_q, count_d;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == FQ_CNT_W'(FQ_DEPTH));
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + FQ_PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + FQ_PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + FQ_CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - FQ_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero before the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FQ_DEPTH; i++) mem_q[i] <= '0;
    end else if (!flush_i && do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush_i) assert (!(push_i && full));
  end

endmodule

// File: rtl/fetch_unit_buffered.sv
// Instruction fetch stage with a decoupling queue and same-cycle redirect flush.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_flush_cnt counters.
module fetch_unit_buffered
  import fetch_pkg::*;
#(
  parameter pc_t PC_STEP  = pc_t'(1),
  parameter pc_t RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  localparam int OCC_W = FQ_CNT_W + 1;

  pc_t          pc_q, pc_d;
  pc_t          req_pc_q, req_pc_d;
  logic         inflight_q, inflight_d;
  fq_cnt_t      fq_count;
  logic         fq_empty;
  logic         fq_push;
  logic         fq_pop;
  fetch_entry_t fq_head;
  fetch_entry_t fq_push_data;
  logic [OCC_W-1:0] occupancy;
  logic         issue;

  // A request is only issued when the queue plus the outstanding response
  // still fits, so a response can always be pushed without back-pressure.
  assign occupancy = {1'b0, fq_count} + OCC_W'(inflight_q);
  assign issue     = rst_n && !redirect_valid && (occupancy < OCC_W'(FQ_DEPTH));

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  assign fq_push      = inflight_q && !redirect_valid;
  assign fq_push_data = '{pc: req_pc_q, instr: imem_rdata};
  assign fq_pop       = if_valid && if_ready && !redirect_valid;

  assign if_valid = !fq_empty;
  assign if_pc    = fq_head.pc;
  assign if_instr = fq_head.instr;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d     = pc_q + PC_STEP;
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_queue u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (fq_push),
    .push_data_i (fq_push_data),
    .pop_i       (fq_pop),
    .head_o      (fq_head),
    .empty_o     (fq_empty),
    .count_o     (fq_count)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (fq_pop)         fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect_valid) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
